// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder on the far side of the core's load/store interface.
// It accepts an active-low chip-select request, waits a fixed number of cycles,
// then performs either a byte-masked word store or a full-word load. Loads
// always return the whole aligned word. The core's load/store unit extracts
// the lane and applies any sign or zero extension.
//
// Parameters
//   DEPTH_WORDS  memory size in 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles between request capture and response (0..15)
//
// Ports
//   clk    in   clock; all state updates on the rising edge
//   rst_n  in   asynchronous active-low reset
//   cs     in   chip select, active-low; 0 = request present
//   we     in   1 = store, 0 = load
//   addr   in   byte address; word index = addr[AW+1:2]
//   mask   in   byte-lane enables for stores
//   wdata  in   store data, lane-aligned by the initiator
//   rdata  out  registered read word; holds until the next load completes
//   ready  out  one-cycle pulse when the access completes
//   stall  out  combinational; the core must hold its request while high
//   err    out  out-of-range pulse coincident with ready (DMEM_ERR_EN only)
//
// Configuration
//   DMEM_ERR_EN  When defined, the err port exists. Any access with nonzero
//                address bits above the memory range is then rejected:
//                stores are dropped and loads return zero.
//                When undefined, the upper address bits are ignored and
//                addresses wrap modulo the memory size.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cs,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  mask,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        stall
`ifdef DMEM_ERR_EN
   ,
   output logic        err
`endif
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // Request fields captured in IDLE and held until the access is performed.
   logic          we_q;
   logic [AW-1:0] idx_q;
   logic [3:0]    mask_q;
   logic [31:0]   wdata_q;

   logic capture;
   logic access;

   // Operands of the access performed on the edge entering RESP.
   logic          in_idle;
   logic          acc_we;
   logic [AW-1:0] acc_idx;
   logic [3:0]    acc_mask;
   logic [31:0]   acc_wdata;
   logic          acc_oor;

   logic [31:0] mem [DEPTH_WORDS];

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      access  = 1'b0;
      stall   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!cs) begin
               stall   = 1'b1;
               capture = 1'b1;
               cnt_d   = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  // With no wait states, the access happens on the capture edge,
                  // using the live inputs.
                  state_d = StResp;
                  access  = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
               access  = 1'b1;
            end
         end
         StResp: begin
            // cs is deliberately ignored here: a request still held low belongs
            // to the instruction that is just completing.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ready = (state_q == StResp);

   // ---------------------------------------------------------------------------
   // Request capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         idx_q   <= '0;
         mask_q  <= 4'd0;
         wdata_q <= 32'd0;
      end else if (capture) begin
         we_q    <= we;
         idx_q   <= addr[AW+1:2];
         mask_q  <= mask;
         wdata_q <= wdata;
      end
   end

   assign in_idle   = (state_q == StIdle);
   assign acc_we    = in_idle ? we           : we_q;
   assign acc_idx   = in_idle ? addr[AW+1:2] : idx_q;
   assign acc_mask  = in_idle ? mask         : mask_q;
   assign acc_wdata = in_idle ? wdata        : wdata_q;

`ifdef DMEM_ERR_EN
   logic oor_q;
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oor_q <= 1'b0;
      end else if (capture) begin
         oor_q <= (addr[31:AW+2] != '0);
      end
   end

   assign acc_oor = in_idle ? (addr[31:AW+2] != '0) : oor_q;

   // err_q is set only on the edge entering RESP, so it is high exactly in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= access & acc_oor;
      end
   end

   assign err = err_q;

   logic unused_addr;
   assign unused_addr = ^addr[1:0];
`else
   assign acc_oor = 1'b0;

   logic unused_addr;
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

   // ---------------------------------------------------------------------------
   // Storage (not reset) and read register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (access && acc_we && !acc_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_mask[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= 32'd0;
      end else if (access && !acc_we) begin
         rdata <= acc_oor ? 32'd0 : mem[acc_idx];
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. It uses two instances:
// one with WAIT_STATES=2, driven by directed and random accesses;
// and one with WAIT_STATES=0, exercising cs held low through RESP.
// A word-array reference model predicts load data and out-of-range behaviour.
// Honours DMEM_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WS2   = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // WAIT_STATES = 2 instance
   logic        cs2, we2;
   logic [31:0] addr2, wdata2, rdata2;
   logic [3:0]  mask2;
   logic        ready2, stall2;

   // WAIT_STATES = 0 instance
   logic        cs0, we0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0]  mask0;
   logic        ready0, stall0;

`ifdef DMEM_ERR_EN
   logic err2, err0;
`endif

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs2),
      .we    (we2),
      .addr  (addr2),
      .mask  (mask2),
      .wdata (wdata2),
      .rdata (rdata2),
      .ready (ready2),
      .stall (stall2)
`ifdef DMEM_ERR_EN
      ,
      .err   (err2)
`endif
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs0),
      .we    (we0),
      .addr  (addr0),
      .mask  (mask0),
      .wdata (wdata0),
      .rdata (rdata0),
      .ready (ready0),
      .stall (stall0)
`ifdef DMEM_ERR_EN
      ,
      .err   (err0)
`endif
   );

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   logic [31:0] mdl [DEPTH];
   logic [31:0] last_rd = 32'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic err2_now();
`ifdef DMEM_ERR_EN
      return err2;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic err0_now();
`ifdef DMEM_ERR_EN
      return err0;
`else
      return 1'b0;
`endif
   endfunction

   // One handshake on dut2. It is entered #1 after a rising edge with the DUT
   // idle, and it returns at the same phase with the DUT idle again.
   // Inputs are scrambled after capture to show that they are ignored.
   task automatic acc2(input logic w, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
      cs2 = 1'b0; we2 = w; addr2 = a; mask2 = m; wdata2 = d;
      for (int k = 0; k <= int'(WS2) + 1; k++) begin
         @(negedge clk);
         if (k <= int'(WS2)) begin
            check_val("hs_wait", {29'd0, stall2, ready2, err2_now()}, 32'b100);
         end else begin
            check_val("hs_resp", {29'd0, stall2, ready2, err2_now()}, {29'd0, 2'b01, exp_err});
            check_val("rdata", rdata2, exp_rd);
         end
         @(posedge clk);
         #1;
         if (k == 0) begin
            cs2 = 1'($urandom); we2 = 1'($urandom); addr2 = $urandom;
            mask2 = 4'($urandom); wdata2 = $urandom;
         end
      end
      cs2 = 1'b1;
   endtask

   // Reference model: word index and range from plain address arithmetic.
   task automatic m_access(input logic w, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] d);
      int unsigned widx = (a / 4) % DEPTH;
      logic oor;
`ifdef DMEM_ERR_EN
      oor = ((a / 4) >= DEPTH);
`else
      oor = 1'b0;
`endif
      if (!w) last_rd = oor ? 32'd0 : mdl[widx];
      acc2(w, a, m, d, last_rd, oor);
      if (w && !oor) begin
         for (int i = 0; i < 4; i++) begin
            if (m[i]) mdl[widx][8*i +: 8] = d[8*i +: 8];
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cs2 = 1'b1; we2 = 1'b0; addr2 = '0; mask2 = '0; wdata2 = '0;
      cs0 = 1'b1; we0 = 1'b0; addr0 = '0; mask0 = '0; wdata0 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_outs2", {28'd0, stall2, ready2, err2_now(), 1'b0}, 32'd0);
      check_val("rst_rdata2", rdata2, 32'd0);
      check_val("rst_outs0", {28'd0, stall0, ready0, err0_now(), 1'b0}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Give the 16-word test window known contents.
      for (int i = 0; i < 16; i++) begin
         mdl[i] = $urandom;
         m_access(1'b1, 32'(i * 4), 4'hF, mdl[i]);
      end

      // Directed store/load and byte-lane merge.
      m_access(1'b1, 32'h08, 4'hF, 32'hDEADBEEF);
      m_access(1'b0, 32'h08, 4'h0, 32'h0);
      check_val("dir_beef", last_rd, 32'hDEADBEEF);
      m_access(1'b1, 32'h08, 4'hF, 32'h11223344);
      m_access(1'b1, 32'h08, 4'b0100, 32'h00AA0000);
      m_access(1'b1, 32'h08, 4'b0011, 32'h00005566);
      m_access(1'b0, 32'h08, 4'hF, 32'h0);
      check_val("dir_merge", last_rd, 32'h11AA5566);
      m_access(1'b1, 32'h08, 4'b0000, 32'hFFFFFFFF);
      m_access(1'b0, 32'h08, 4'h0, 32'h0);
      check_val("dir_mask0", last_rd, 32'h11AA5566);

      // Out-of-range access: either an error or an alias of word 2.
      m_access(1'b1, 32'h0000_1008, 4'hF, 32'hA5A55A5A);
      m_access(1'b0, 32'h0000_1008, 4'h0, 32'h0);
      m_access(1'b0, 32'h0000_0008, 4'h0, 32'h0);

      // Reset in mid-WAIT of a store drops that store.
      m_access(1'b1, 32'h10, 4'hF, 32'h12345678);
      m_access(1'b0, 32'h10, 4'h0, 32'h0);
      cs2 = 1'b0; we2 = 1'b1; addr2 = 32'h10; mask2 = 4'hF; wdata2 = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      cs2 = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("abort_outs", {28'd0, stall2, ready2, err2_now(), 1'b0}, 32'd0);
      check_val("abort_rdata", rdata2, 32'd0);
      last_rd = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("abort_idle", {30'd0, stall2, ready2}, 32'd0);
      m_access(1'b0, 32'h10, 4'h0, 32'h0);
      check_val("abort_keep", last_rd, 32'h12345678);

      // Random traffic within the window, sometimes with upper address bits.
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
         m_access(1'($urandom), a, 4'($urandom), $urandom);
      end

      // WAIT_STATES=0: cs held low across RESP and into the next IDLE.
      cs0 = 1'b0; we0 = 1'b1; addr0 = 32'h0C; mask0 = 4'hF; wdata0 = 32'h0C0C0C0C;
      @(negedge clk);
      check_val("ws0_req1", {30'd0, stall0, ready0}, 32'b10);
      @(posedge clk);
      #1;
      we0 = 1'b0; wdata0 = 32'h0;
      @(negedge clk);
      check_val("ws0_resp1", {30'd0, stall0, ready0}, 32'b01);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("ws0_req2", {30'd0, stall0, ready0}, 32'b10);
      @(posedge clk);
      #1;
      cs0 = 1'b1;
      @(negedge clk);
      check_val("ws0_resp2", {30'd0, stall0, ready0}, 32'b01);
      check_val("ws0_rdata", rdata0, 32'h0C0C0C0C);
      @(negedge clk);
      check_val("ws0_quiet", {30'd0, stall0, ready0}, 32'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
